lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit between the core's memory stage and the word-addressed data RAM (combinational read, synchronous word write, byte address shifted right by 2 inside the RAM).
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW: lane extraction, sign/zero extension, alignment checks.
- Implements sub-word stores as read-modify-write, since the RAM has word writes only.
- Single-outstanding request/done handshake toward the core.

Parameters:
- ADDR_WIDTH, 32, width of byte address on core and RAM sides.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  core request valid
- o_ready  output  1  unit idle, request accepted when i_valid && o_ready
- i_store  input  1  1 = store, 0 = load
- i_funct3  input  3  RV32I funct3 of the access
- i_addr  input  ADDR_WIDTH  byte address
- i_wdata  input  32  store data, right-aligned
- o_rdata  output  32  load result, extended
- o_done  output  1  one-cycle completion pulse
- o_fault  output  1  completion had misalignment or illegal funct3; valid with o_done
- o_mem_we  output  1  RAM write enable
- o_mem_addr  output  ADDR_WIDTH  RAM byte address, bits[1:0] forced 0
- o_mem_wdata  output  32  RAM write word
- i_mem_rdata  input  32  RAM read word (combinational from o_mem_addr)

Behaviour:
- Reset (synchronous, i_rst=1 at edge):
  - state IDLE
  - o_rdata = 0, o_done = 0, o_fault = 0, o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0
  - all latched request registers = 0
  - Reset has priority over every transition.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE:
  - o_ready = 1. On i_valid, latch i_store, i_funct3, i_addr, i_wdata.
  - Fault check at accept: funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]≠0.
  - Fault -> RESP with fault flag set; no RAM access.
  - Otherwise: load -> LOAD; SW -> WRITE; SB/SH -> RMW_READ.
- LOAD: o_mem_addr = latched addr & ~3. At the edge, extract lane from i_mem_rdata into o_rdata, then go to RESP.
  - Lanes are little-endian: byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the whole word.
- RMW_READ: o_mem_addr aligned. At the edge, register the merge word = i_mem_rdata with the addressed byte (SB) or halfword (SH) replaced by i_wdata[7:0] or i_wdata[15:0]. Go to WRITE.
- WRITE: o_mem_we = 1 for exactly this cycle. o_mem_wdata = merge word (SB/SH) or latched i_wdata (SW). Go to RESP.
- RESP:
  - o_done = 1 for exactly one cycle; o_fault valid.
  - o_rdata holds the load value; for stores/faults o_rdata is unchanged from its previous value.
  - Go to IDLE.
- o_ready is 0 in every state except IDLE. i_valid outside IDLE is ignored; the core must hold it until accepted.
- Latency from accept edge to o_done high: load 2 cycles, SW 2, SB/SH 3, fault 1.
- Next request can be accepted the cycle after RESP.
- o_mem_we is never asserted outside WRITE, and never for a faulting request.
- Reset mid-operation:
  - RAM is unmodified if reset is sampled before WRITE.
  - No o_done is generated for an aborted request.
- o_mem_addr is held from the latched address between operations, so it is stable throughout RMW_READ→WRITE.

Test Plan:
- RAM[0x10] = 0x8899AABB; LB @0x11 -> o_done 2 cycles after accept, o_rdata = 0xFFFFFFAA, o_fault = 0.
- LBU @0x13 -> 0x00000088; LH @0x12 -> 0xFFFF8899; LHU @0x10 -> 0x0000AABB; LW @0x10 -> 0x8899AABB.
- SB @0x12 wdata 0x123456CC:
  - o_mem_we high exactly 1 cycle, o_mem_addr = 0x10, o_mem_wdata = 0x88CCAABB.
  - o_done 3 cycles after accept; subsequent LW @0x10 = 0x88CCAABB.
- SW @0x14 wdata 0xDEADBEEF -> one write 0xDEADBEEF @0x14, o_done 2 cycles after accept.
- Faults, each with o_done and o_fault after 1 cycle, o_mem_we never high:
  - SH @0x11
  - LW @0x12
  - load with funct3 = 011
- i_rst asserted during RMW_READ of SB @0x10:
  - no o_mem_we, no o_done, o_ready = 1 next cycle, RAM[0x10] unchanged.
- i_valid held high continuously with back-to-back loads -> each accepted only in IDLE; o_ready low in LOAD/RESP.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit between the core memory stage and a word-addressed data RAM.
// Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW with little-endian lane handling.
// Sub-word stores are done as a read-modify-write because the RAM has word
// writes only. There is one outstanding request at a time, with a one-cycle
// completion pulse.
//
// Ports:
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_valid / o_ready  request handshake; a request is accepted when both are high
//   i_store, i_funct3  access kind: store flag and RV32I funct3
//   i_addr, i_wdata    byte address and right-aligned store data
//   o_rdata            extended load result, held until the next load
//   o_done, o_fault    completion pulse; fault flag for misalignment or illegal funct3
//   o_mem_*            RAM word port (combinational read, synchronous write)
module lsu #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_store,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata,
   output logic                  o_done,
   output logic                  o_fault,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [31:0]           o_mem_wdata,
   input  logic [31:0]           i_mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_READ,
      WRITE,
      RESP
   } state_t;

   state_t                  state;
   state_t                  state_next;

   logic                    store_q;
   logic [2:0]              funct3_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic [31:0]             merge_q;
   logic [31:0]             rdata_q;
   logic                    fault_q;

   logic                    accept;
   logic                    accept_fault;
   logic [7:0]              lane_byte;
   logic [15:0]             lane_half;
   logic [31:0]             load_val;
   logic [31:0]             merged;

   assign accept = (state == IDLE) && i_valid;

   // Illegal funct3 for the direction, or an access not aligned to its size.
   always_comb begin
      logic bad_f3;
      logic misaligned;
      bad_f3 = '0;
      misaligned = '0;
      if (i_store)
         bad_f3 = i_funct3[2] || (i_funct3[1:0] == 2'b11);
      else
         bad_f3 = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
      misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
      accept_fault = bad_f3 || misaligned;
   end

   // Lane extraction for loads: the byte lane comes from addr[1:0] and the
   // halfword lane from addr[1].
   always_comb begin
      lane_byte = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_half = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_val = {24'h000000, lane_byte};
         3'b101:  load_val = {16'h0000, lane_half};
         default: load_val = i_mem_rdata;
      endcase
   end

   // Sub-word store merge: the addressed lane of the current RAM word is
   // replaced by the low bits of the store data.
   always_comb begin
      merged = i_mem_rdata;
      if (funct3_q[0] == 1'b0)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (i_valid) begin
               if (accept_fault)
                  state_next = RESP;
               else if (!i_store)
                  state_next = LOAD;
               else if (i_funct3[1:0] == 2'b10)
                  state_next = WRITE;
               else
                  state_next = RMW_READ;
            end
         end
         LOAD:     state_next = RESP;
         RMW_READ: state_next = WRITE;
         WRITE:    state_next = RESP;
         RESP:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         store_q  <= '0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         merge_q  <= '0;
         rdata_q  <= '0;
         fault_q  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            store_q  <= i_store;
            funct3_q <= i_funct3;
            addr_q   <= i_addr;
            wdata_q  <= i_wdata;
            fault_q  <= accept_fault;
         end
         if (state == LOAD)
            rdata_q <= load_val;
         if (state == RMW_READ)
            merge_q <= merged;
      end
   end

   // The RAM address tracks the latched request, so it stays stable from
   // RMW_READ through WRITE and between operations.
   assign o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign o_mem_wdata = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;
   assign o_mem_we    = (state == WRITE) && store_q;
   assign o_ready     = (state == IDLE);
   assign o_done      = (state == RESP);
   assign o_fault     = (state == RESP) && fault_q;
   assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases with hand-computed results plus
// randomized traffic compared each cycle against a transaction-level model.
module tb_lsu;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic          ready;
   logic          store;
   logic [2:0]    f3;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          done;
   logic          fault;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0]   ram    [0:63];
   logic [31:0]   shadow [0:63];

   int n_cmp = 0;
   int n_bad = 0;
   int we_count = 0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;

   always #5 clk = ~clk;

   lsu #(.ADDR_WIDTH(AW)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_store     (store),
      .i_funct3    (f3),
      .i_addr      (addr),
      .i_wdata     (wdata),
      .o_rdata     (rdata),
      .o_done      (done),
      .o_fault     (fault),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   // Environment RAM: combinational read, synchronous word write.
   assign mem_rdata = ram[mem_addr[7:2]];
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr[7:2]] <= mem_wdata;
         we_count   <= we_count + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit legal(input bit st, input logic [2:0] fn, input logic [1:0] off);
      int size;
      bit ok_fn;
      if (st) ok_fn = (fn == 0) || (fn == 1) || (fn == 2);
      else    ok_fn = (fn == 0) || (fn == 1) || (fn == 2) || (fn == 4) || (fn == 5);
      size = 1 << fn[1:0];
      return ok_fn && ((int'(off) % size) == 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] fn, input logic [1:0] off,
                                              input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> (8 * off);
      case (fn)
         3'd0:    return 32'($signed(sh[7:0]));
         3'd1:    return 32'($signed(sh[15:0]));
         3'd4:    return sh & 32'h0000_00FF;
         3'd5:    return sh & 32'h0000_FFFF;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_merge(input logic [2:0] fn, input logic [1:0] off,
                                               input logic [31:0] old, input logic [31:0] wd);
      logic [31:0] mask;
      mask = ((fn == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
      return (old & ~mask) | ((wd << (8 * off)) & mask);
   endfunction

   bit          m_busy = 0;
   int          m_cyc = 0;
   int          m_lat = 0;
   int          m_we_cyc = 0;
   bit          m_fault = 0;
   bit          m_is_load = 0;
   logic [31:0] m_rdata = '0;
   logic [31:0] m_load_val = '0;
   logic [31:0] m_waddr = '0;
   logic [31:0] m_wword = '0;

   // Compare outputs mid-cycle, then advance the model using the inputs that
   // the next rising edge will sample.
   always @(negedge clk) begin : cmp
      bit exp_done;
      bit exp_we;
      logic [1:0] off;
      int idx;
      exp_done = m_busy && (m_cyc == m_lat);
      exp_we   = m_busy && (m_cyc == m_we_cyc);
      check("ready", 32'(ready), 32'(!m_busy));
      check("done", 32'(done), 32'(exp_done));
      check("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
         check("mem_addr", mem_addr, m_waddr);
         check("mem_wdata", mem_wdata, m_wword);
         shadow[m_waddr[7:2]] = m_wword;
      end
      if (exp_done) begin
         check("fault", 32'(fault), 32'(m_fault));
         if (m_is_load && !m_fault) m_rdata = m_load_val;
         check("rdata", rdata, m_rdata);
      end
      if (rst) begin
         m_busy  = 0;
         m_rdata = '0;
      end else if (m_busy) begin
         if (m_cyc == m_lat) m_busy = 0;
         else m_cyc++;
      end else if (valid) begin
         off = addr[1:0];
         idx = int'(addr[7:2]);
         m_busy    = 1;
         m_cyc     = 1;
         m_we_cyc  = 0;
         m_is_load = !store;
         m_fault   = !legal(store, f3, off);
         m_waddr   = addr & 32'hFFFF_FFFC;
         if (m_fault) begin
            m_lat = 1;
         end else if (!store) begin
            m_lat      = 2;
            m_load_val = model_load(f3, off, shadow[idx]);
         end else if (f3 == 3'd2) begin
            m_lat    = 2;
            m_we_cyc = 1;
            m_wword  = wdata;
         end else begin
            m_lat    = 3;
            m_we_cyc = 2;
            m_wword  = model_merge(f3, off, shadow[idx], wdata);
         end
      end
   end

   // ---------------- directed driver ----------------
   task automatic do_req(input bit st, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic flt, output int lat);
      int w;
      store = st;
      f3    = fn;
      addr  = a;
      wdata = wd;
      valid = 1'b1;
      w = 0;
      while (!ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      valid = 1'b0;
      lat = 0;
      rd  = 'x;
      flt = 1'bx;
      w = 1;
      while (lat == 0 && w <= 10) begin
         if (done) begin
            lat = w;
            rd  = rdata;
            flt = fault;
         end else begin
            @(posedge clk); #1;
            w++;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic        flt;
      int          lat;
      int          we0;

      rst = 1'b1; valid = 1'b0; store = 1'b0; f3 = '0; addr = '0; wdata = '0;
      for (int i = 0; i < 64; i++) begin
         ram[i]    = $urandom;
         shadow[i] = ram[i];
      end
      ram[4]    = 32'h8899_AABB;
      shadow[4] = 32'h8899_AABB;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_maddr", mem_addr, 32'd0);
      check("rst_mwdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_req(0, 3'd0, 32'h11, 0, rd, flt, lat);
      check("lb_val", rd, 32'hFFFF_FFAA); check("lb_lat", lat, 2); check("lb_flt", 32'(flt), 0);
      do_req(0, 3'd4, 32'h13, 0, rd, flt, lat);
      check("lbu_val", rd, 32'h0000_0088);
      do_req(0, 3'd1, 32'h12, 0, rd, flt, lat);
      check("lh_val", rd, 32'hFFFF_8899);
      do_req(0, 3'd5, 32'h10, 0, rd, flt, lat);
      check("lhu_val", rd, 32'h0000_AABB);
      do_req(0, 3'd2, 32'h10, 0, rd, flt, lat);
      check("lw_val", rd, 32'h8899_AABB);

      we0 = we_count;
      do_req(1, 3'd0, 32'h12, 32'h1234_56CC, rd, flt, lat);
      check("sb_lat", lat, 3);
      check("sb_wecnt", we_count - we0, 1);
      check("sb_waddr", last_waddr, 32'h10);
      check("sb_wdata", last_wdata, 32'h88CC_AABB);
      do_req(0, 3'd2, 32'h10, 0, rd, flt, lat);
      check("lw_after_sb", rd, 32'h88CC_AABB);

      we0 = we_count;
      do_req(1, 3'd2, 32'h14, 32'hDEAD_BEEF, rd, flt, lat);
      check("sw_lat", lat, 2);
      check("sw_wecnt", we_count - we0, 1);
      check("sw_waddr", last_waddr, 32'h14);
      check("sw_wdata", last_wdata, 32'hDEAD_BEEF);

      we0 = we_count;
      do_req(1, 3'd1, 32'h11, 32'h5555, rd, flt, lat);
      check("sh_mis_lat", lat, 1); check("sh_mis_flt", 32'(flt), 1);
      check("sh_mis_rdata", rd, 32'h88CC_AABB);
      do_req(0, 3'd2, 32'h12, 0, rd, flt, lat);
      check("lw_mis_lat", lat, 1); check("lw_mis_flt", 32'(flt), 1);
      do_req(0, 3'd3, 32'h10, 0, rd, flt, lat);
      check("ld_f3_lat", lat, 1); check("ld_f3_flt", 32'(flt), 1);
      check("fault_wecnt", we_count - we0, 0);

      // Reset while the SB is in its read phase.
      we0 = we_count;
      store = 1'b1; f3 = 3'd0; addr = 32'h10; wdata = 32'h0000_0011; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      check("abort_busy", 32'(ready), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ready", 32'(ready), 1);
      check("abort_done", 32'(done), 0);
      check("abort_rdata", rdata, 0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_wecnt", we_count - we0, 0);
      check("abort_ram", ram[4], 32'h88CC_AABB);

      // Back-to-back loads with i_valid held high.
      store = 1'b0; f3 = 3'd2; addr = 32'h14; valid = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Randomized traffic, including occasional resets.
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 63) == 0);
         valid = $urandom_range(0, 1);
         store = $urandom_range(0, 1);
         f3    = 3'($urandom_range(0, 7));
         addr  = 32'($urandom_range(0, 255));
         wdata = $urandom;
         @(posedge clk); #1;
      end
      rst = 1'b0; valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < 64; i++) check("ram_final", ram[i], shadow[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
